hist_calc_pipe: RTL and testbench

HIST_CALC_PIPE -- requirements
Module: hist_calc_pipe

---
 rtl/hist_calc_pipe.sv | 154 +++++++++++++++
 tb/tb_hist_calc_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_calc_pipe.sv
// Frame histogram engine: erases the bin RAM, then accumulates one frame of pixels
// through a 3-stage read-modify-write pipeline with in-flight forwarding.
module hist_calc_pipe #(
    parameter int PIX_W = 14,
    parameter int BIN_W = 14,
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             hist_upd,
    output logic             hist_rdy,
    input  logic [15:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic [BIN_W-1:0] ram_raddr,
    input  logic [CNT_W-1:0] ram_dout,
    output logic             ram_we,
    output logic [BIN_W-1:0] ram_waddr,
    output logic [CNT_W-1:0] ram_din,
    output logic [31:0]      pix_cnt,
    output logic             sat_flag
);

    typedef enum logic [2:0] {IDLE, ERASE, WAIT_SOF, ACCUM, FLUSH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [BIN_W-1:0] erase_addr;

    // Stage 1 bin lives in ram_raddr; stage 3 lives in ram_waddr/ram_din.
    logic             s1_valid;
    logic             s2_valid;
    logic [BIN_W-1:0] s2_bin;
    logic             s3_valid;
    logic             s4_valid;
    logic [BIN_W-1:0] s4_bin;
    logic [CNT_W-1:0] s4_new;

    logic             sof;
    logic             good;
    logic             bin_it;
    logic [BIN_W-1:0] pix_bin;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] new_cnt;
    logic             at_max;
    logic             unused_inputs;

    assign s_axis_tready = 1'b1;
    assign unused_inputs = ^{s_axis_tlast, s_axis_tdata};

    always_comb begin
        sof     = s_axis_tvalid & s_axis_tuser;
        good    = s_axis_tvalid & s_axis_tdata[15];
        pix_bin = s_axis_tdata[PIX_W-1 -: BIN_W];
        bin_it  = 1'b0;
        case (state)
            WAIT_SOF: bin_it = sof & good;
            ACCUM:    bin_it = good & ~sof;
            default:  bin_it = 1'b0;
        endcase

        // Stage 4 holds the write that coincided with our RAM read, which returned stale data.
        if (s3_valid && (ram_waddr == s2_bin))
            base = ram_din;
        else if (s4_valid && (s4_bin == s2_bin))
            base = s4_new;
        else
            base = ram_dout;

        at_max  = (base == CNT_MAX);
        new_cnt = at_max ? base : base + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= IDLE;
            hist_rdy   <= 1'b1;
            ram_we     <= 1'b0;
            ram_raddr  <= '0;
            ram_waddr  <= '0;
            ram_din    <= '0;
            pix_cnt    <= '0;
            sat_flag   <= 1'b0;
            erase_addr <= '0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s2_bin     <= '0;
            s3_valid   <= 1'b0;
            s4_valid   <= 1'b0;
            s4_bin     <= '0;
            s4_new     <= '0;
        end else begin
            s1_valid <= bin_it;
            if (bin_it)
                ram_raddr <= pix_bin;
            s2_valid <= s1_valid;
            s2_bin   <= ram_raddr;
            s3_valid <= s2_valid;
            s4_valid <= s3_valid;
            s4_bin   <= ram_waddr;
            s4_new   <= ram_din;

            ram_we <= s2_valid;
            if (s2_valid) begin
                ram_waddr <= s2_bin;
                ram_din   <= new_cnt;
                if (at_max)
                    sat_flag <= 1'b1;
            end

            if (bin_it && (pix_cnt != '1))
                pix_cnt <= pix_cnt + 32'd1;

            case (state)
                IDLE: begin
                    if (hist_upd) begin
                        hist_rdy   <= 1'b0;
                        pix_cnt    <= '0;
                        sat_flag   <= 1'b0;
                        erase_addr <= '0;
                        state      <= ERASE;
                    end
                end
                ERASE: begin
                    ram_we     <= 1'b1;
                    ram_waddr  <= erase_addr;
                    ram_din    <= '0;
                    erase_addr <= erase_addr + 1'b1;
                    if (erase_addr == '1)
                        state <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (sof)
                        state <= ACCUM;
                end
                ACCUM: begin
                    if (sof)
                        state <= FLUSH;
                end
                FLUSH: begin
                    if (!s1_valid && !s2_valid && !s3_valid) begin
                        hist_rdy <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hist_calc_pipe.sv
// Bench for hist_calc_pipe: three parameterisations share one stimulus stream;
// the default instance's RAM writes are checked against a scoreboard.
module tb_hist_calc_pipe;

    logic        clk = 1'b0;
    logic        srst;
    logic        hist_upd;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tuser;
    logic        prefill;
    logic        in_erase;

    always #5 clk = ~clk;

    // Instance A: defaults (14/14/18)
    logic        a_rdy, a_tready, a_we, a_sat;
    logic [13:0] a_raddr, a_waddr;
    logic [17:0] a_dout, a_din;
    logic [31:0] a_pix;
    // Instance B: BIN_W=8
    logic        b_rdy, b_tready, b_we, b_sat;
    logic [7:0]  b_raddr, b_waddr;
    logic [17:0] b_dout, b_din;
    logic [31:0] b_pix;
    // Instance C: CNT_W=2
    logic        c_rdy, c_tready, c_we, c_sat;
    logic [13:0] c_raddr, c_waddr;
    logic [1:0]  c_dout, c_din;
    logic [31:0] c_pix;

    hist_calc_pipe dut_a (
        .clk(clk), .srst(srst), .hist_upd(hist_upd), .hist_rdy(a_rdy),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(a_tready),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .ram_raddr(a_raddr), .ram_dout(a_dout), .ram_we(a_we), .ram_waddr(a_waddr),
        .ram_din(a_din), .pix_cnt(a_pix), .sat_flag(a_sat)
    );

    hist_calc_pipe #(.PIX_W(14), .BIN_W(8), .CNT_W(18)) dut_b (
        .clk(clk), .srst(srst), .hist_upd(hist_upd), .hist_rdy(b_rdy),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(b_tready),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .ram_raddr(b_raddr), .ram_dout(b_dout), .ram_we(b_we), .ram_waddr(b_waddr),
        .ram_din(b_din), .pix_cnt(b_pix), .sat_flag(b_sat)
    );

    hist_calc_pipe #(.PIX_W(14), .BIN_W(14), .CNT_W(2)) dut_c (
        .clk(clk), .srst(srst), .hist_upd(hist_upd), .hist_rdy(c_rdy),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(c_tready),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .ram_raddr(c_raddr), .ram_dout(c_dout), .ram_we(c_we), .ram_waddr(c_waddr),
        .ram_din(c_din), .pix_cnt(c_pix), .sat_flag(c_sat)
    );

    // Synchronous RAMs, read-during-write returns old data; prefill seeds garbage.
    logic [17:0] mem_a [0:16383];
    logic [17:0] mem_b [0:255];
    logic [1:0]  mem_c [0:16383];

    always @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < 16384; i++) mem_a[i] <= 18'h2AAAA;
            for (int i = 0; i < 256; i++)   mem_b[i] <= 18'h15555;
            for (int i = 0; i < 16384; i++) mem_c[i] <= 2'b10;
        end else begin
            if (a_we) mem_a[a_waddr] <= a_din;
            if (b_we) mem_b[b_waddr] <= b_din;
            if (c_we) mem_c[c_waddr] <= c_din;
        end
        a_dout <= mem_a[a_raddr];
        b_dout <= mem_b[b_raddr];
        c_dout <= mem_c[c_raddr];
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected pipeline writes for instance A.
    typedef struct packed {
        logic [13:0] bin;
        logic [17:0] cnt;
    } wr_t;
    wr_t         sb_q[$];
    logic [17:0] mdl_hist [0:16383];
    logic        mdl_accum;
    int          ea_cnt, eb_cnt, ec_cnt;

    always @(negedge clk) begin
        if (in_erase) begin
            if (a_we) begin
                check("erase_waddr_a", 32'(a_waddr), 32'(ea_cnt));
                check("erase_din_a", 32'(a_din), 32'd0);
                ea_cnt++;
            end
            if (b_we) eb_cnt++;
            if (c_we) ec_cnt++;
        end else if (a_we) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 32'(a_waddr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("sb_waddr", 32'(a_waddr), 32'(e.bin));
                check("sb_din", 32'(a_din), 32'(e.cnt));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic user, input logic last);
        logic        do_bin;
        logic [13:0] b;
        do_bin = 1'b0;
        if (user) begin
            if (!mdl_accum) begin
                mdl_accum = 1'b1;
                do_bin    = d[15];
            end else begin
                mdl_accum = 1'b0;
            end
        end else if (mdl_accum) begin
            do_bin = d[15];
        end
        if (do_bin) begin
            b = d[13:0];
            if (mdl_hist[b] != 18'h3FFFF) mdl_hist[b] = mdl_hist[b] + 18'd1;
            sb_q.push_back({b, mdl_hist[b]});
        end
        tdata  = d;
        tuser  = user;
        tlast  = last;
        tvalid = 1'b1;
        step();
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic do_upd();
        in_erase  = 1'b1;
        ea_cnt    = 0;
        eb_cnt    = 0;
        ec_cnt    = 0;
        mdl_accum = 1'b0;
        for (int i = 0; i < 16384; i++) mdl_hist[i] = '0;
        hist_upd = 1'b1;
        step();
        hist_upd = 1'b0;
        check("upd_rdy_low_a", 32'(a_rdy), 32'd0);
        check("upd_pix_clr_a", a_pix, 32'd0);
        check("upd_sat_clr_c", 32'(c_sat), 32'd0);
    endtask

    task automatic wait_erase();
        for (int k = 0; k < 16400; k++) begin
            if (ea_cnt == 16384 && ec_cnt == 16384) break;
            step();
        end
        step();
        step();
        check("erase_count_a", 32'(ea_cnt), 32'd16384);
        check("erase_count_b", 32'(eb_cnt), 32'd256);
        check("erase_count_c", 32'(ec_cnt), 32'd16384);
        in_erase = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!a_rdy && n < 20) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int nz;
        srst     = 1'b1;
        hist_upd = 1'b0;
        tdata    = '0;
        tvalid   = 1'b0;
        tlast    = 1'b0;
        tuser    = 1'b0;
        in_erase = 1'b0;
        prefill  = 1'b1;
        step();
        prefill = 1'b0;
        step();
        step();

        check("rst_rdy", 32'(a_rdy), 32'd1);
        check("rst_tready", 32'(a_tready), 32'd1);
        check("rst_we", 32'(a_we), 32'd0);
        check("rst_raddr", 32'(a_raddr), 32'd0);
        check("rst_waddr", 32'(a_waddr), 32'd0);
        check("rst_din", 32'(a_din), 32'd0);
        check("rst_pix", a_pix, 32'd0);
        check("rst_sat", 32'(a_sat), 32'd0);
        srst = 1'b0;
        step();

        // Cycle 1: erase over prefilled RAM, then frame 5,5,5,5
        do_upd();
        wait_erase();
        nz = 0;
        for (int i = 0; i < 16384; i++) if (mem_a[i] != 0) nz++;
        check("erase_zero_a", 32'(nz), 32'd0);
        nz = 0;
        for (int i = 0; i < 256; i++) if (mem_b[i] != 0) nz++;
        check("erase_zero_b", 32'(nz), 32'd0);
        nz = 0;
        for (int i = 0; i < 16384; i++) if (mem_c[i] != 0) nz++;
        check("erase_zero_c", 32'(nz), 32'd0);

        beat(16'h8005, 1'b0, 1'b0);  // before SOF: discarded
        step();
        beat(16'h8005, 1'b1, 1'b0);
        beat(16'h8005, 1'b0, 1'b0);
        beat(16'h8005, 1'b0, 1'b0);
        beat(16'h8005, 1'b0, 1'b1);
        beat(16'h8005, 1'b1, 1'b0);  // terminating SOF
        check("tready_flush", 32'(a_tready), 32'd1);
        wait_ready(n);
        check("rdy_within_4", 32'(n >= 1 && n <= 4), 32'd1);
        check("f1_bin5_a", 32'(mem_a[5]), 32'd4);
        check("f1_pix_a", a_pix, 32'd4);
        check("f1_sat_a", 32'(a_sat), 32'd0);
        check("f1_sat_c", 32'(c_sat), 32'd1);
        check("f1_sb_empty", 32'(sb_q.size()), 32'd0);
        beat(16'h8005, 1'b0, 1'b0);  // idle beat: discarded
        step();

        // Cycle 2: forwarding pattern, saturation, bin scaling, bad beat
        do_upd();
        wait_erase();
        beat(16'h8007, 1'b1, 1'b0);
        beat(16'h8009, 1'b0, 1'b0);
        beat(16'h8007, 1'b0, 1'b0);
        beat(16'h8009, 1'b0, 1'b0);
        beat(16'h8007, 1'b0, 1'b0);
        step();
        hist_upd = 1'b1;             // ignored outside IDLE
        beat(16'h8003, 1'b0, 1'b0);
        hist_upd = 1'b0;
        check("upd_ignored_rdy", 32'(a_rdy), 32'd0);
        beat(16'h8003, 1'b0, 1'b0);
        beat(16'h8003, 1'b0, 1'b1);
        beat(16'h8003, 1'b0, 1'b0);
        beat(16'h8003, 1'b0, 1'b0);
        beat(16'h0040, 1'b0, 1'b0);  // not a good pixel
        beat(16'h8040, 1'b0, 1'b0);
        beat(16'h807F, 1'b0, 1'b0);
        beat(16'hBFFF, 1'b0, 1'b1);
        beat(16'h8003, 1'b1, 1'b0);
        wait_ready(n);
        check("f2_rdy", 32'(a_rdy), 32'd1);
        check("f2_bin7_a", 32'(mem_a[7]), 32'd3);
        check("f2_bin9_a", 32'(mem_a[9]), 32'd2);
        check("f2_bin3_a", 32'(mem_a[3]), 32'd5);
        check("f2_bin40_a", 32'(mem_a[14'h0040]), 32'd1);
        check("f2_bin7f_a", 32'(mem_a[14'h007F]), 32'd1);
        check("f2_bin3fff_a", 32'(mem_a[14'h3FFF]), 32'd1);
        check("f2_pix_a", a_pix, 32'd13);
        check("f2_sat_a", 32'(a_sat), 32'd0);
        check("f2_bin1_b", 32'(mem_b[1]), 32'd2);
        check("f2_bin255_b", 32'(mem_b[255]), 32'd1);
        check("f2_bin0_b", 32'(mem_b[0]), 32'd10);
        check("f2_pix_b", b_pix, 32'd13);
        check("f2_bin3_c", 32'(mem_c[3]), 32'd3);
        check("f2_bin7_c", 32'(mem_c[7]), 32'd3);
        check("f2_sat_c", 32'(c_sat), 32'd1);
        check("f2_pix_c", c_pix, 32'd13);
        check("f2_sb_empty", 32'(sb_q.size()), 32'd0);

        // Cycle 3: reset in the middle of accumulation
        do_upd();
        wait_erase();
        beat(16'h8001, 1'b1, 1'b0);
        beat(16'h8002, 1'b0, 1'b0);
        check("pre_rst_pix", a_pix, 32'd2);
        srst = 1'b1;
        sb_q.delete();
        mdl_accum = 1'b0;
        step();
        srst = 1'b0;
        check("mid_rst_rdy", 32'(a_rdy), 32'd1);
        check("mid_rst_we", 32'(a_we), 32'd0);
        check("mid_rst_pix", a_pix, 32'd0);
        check("mid_rst_tready", 32'(a_tready), 32'd1);
        for (int k = 0; k < 4; k++) step();
        check("post_rst_rdy", 32'(a_rdy), 32'd1);
        in_erase = 1'b1;
        ea_cnt   = 0;
        hist_upd = 1'b1;
        step();
        hist_upd = 1'b0;
        check("reupd_rdy_low", 32'(a_rdy), 32'd0);
        step();
        check("reupd_erase_we", 32'(a_we), 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
